// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode scan controller: guard gap, PWM brightness and frame-aligned double buffer.
// Outputs are registered (one clock after the slot counter); no backpressure, a load is always accepted.
module seg7_scan_ctrl #(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned GUARD_CYCLES = 1600
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_mask_i,
    input  logic [3:0]  blank_mask_i,
    input  logic [3:0]  brightness_i,
    input  logic        load_i,
    output logic        load_ack_o,
    output logic        frame_tick_o,
    output logic [7:0]  seg_o,
    output logic [3:0]  an_o
);

    localparam int unsigned STEP = (DIGIT_CYCLES - GUARD_CYCLES) / 16;
    localparam int unsigned CW   = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  bright;
    } disp_t;

    localparam disp_t ACT_RST = '{value: 16'h0, dp: 4'h0, blank: 4'hF, bright: 4'h0};

    typedef enum logic [1:0] {ST_GUARD, ST_ON, ST_OFF} state_t;

    logic [CW-1:0] slot_q, slot_d;
    logic [1:0]    digit_q, digit_d;
    state_t        state_q, state_d;
    disp_t         pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    disp_t         act_q, act_d;
    logic          adopt_q, adopt_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          tick_q, tick_d;
    logic          ack_q, ack_d;

    logic          slot_end;
    logic          frame_end;
    logic [31:0]   on_last;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_end  = (slot_q == SLOT_LAST);
    assign frame_end = slot_end && (digit_q == 2'd3);
    // Last slot count of the ON window; equals SLOT_LAST at full brightness.
    assign on_last   = GUARD_CYCLES + (32'(act_q.bright) + 32'd1) * STEP - 32'd1;

    always_comb begin
        slot_d     = slot_end ? '0 : slot_q + 1'b1;
        digit_d    = slot_end ? digit_q + 2'd1 : digit_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        act_d      = act_q;
        adopt_d    = 1'b0;
        state_d    = state_q;
        an_d       = 4'hF;
        seg_d      = 8'hFF;
        tick_d     = (slot_q == '0) && (digit_q == 2'd0);
        ack_d      = adopt_q;

        if (frame_end && pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = 1'b0;
            adopt_d    = 1'b1;
        end
        // A load on the boundary edge lands after adoption, so it waits a frame.
        if (load_i) begin
            pend_d     = '{value: value_i, dp: dp_mask_i, blank: blank_mask_i, bright: brightness_i};
            pend_vld_d = 1'b1;
        end

        case (state_q)
            ST_GUARD: begin
                if (slot_end) begin
                    state_d = ST_GUARD;
                end else if (slot_q == GUARD_LAST) begin
                    state_d = act_q.blank[digit_q] ? ST_OFF : ST_ON;
                end
            end
            ST_ON: begin
                if (slot_end) begin
                    state_d = ST_GUARD;
                end else if (32'(slot_q) == on_last) begin
                    state_d = ST_OFF;
                end
            end
            ST_OFF: begin
                if (slot_end) begin
                    state_d = ST_GUARD;
                end
            end
            default: state_d = ST_GUARD;
        endcase

        if (state_q == ST_ON) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = {~act_q.dp[digit_q], seg_decode(act_q.value[{digit_q, 2'b00} +: 4])};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q     <= '0;
            digit_q    <= 2'd0;
            state_q    <= ST_GUARD;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            act_q      <= ACT_RST;
            adopt_q    <= 1'b0;
            an_q       <= 4'hF;
            seg_q      <= 8'hFF;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            digit_q    <= digit_d;
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            act_q      <= act_d;
            adopt_q    <= adopt_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
        end
    end

    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign frame_tick_o = tick_q;
    assign load_ack_o   = ack_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a short slot (40 clocks, 8 guard, step 2).
module tb_seg7_scan_ctrl;

    localparam int DC = 40;
    localparam int GC = 8;
    localparam int FR = 4 * DC;
    localparam int NL = -1;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic [3:0]  brightness;
    logic        load_ack;
    logic        frame_tick;
    logic [7:0]  seg;
    logic [3:0]  an;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIGIT_CYCLES(DC), .GUARD_CYCLES(GC)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .value_i      (value),
        .dp_mask_i    (dp_mask),
        .blank_mask_i (blank_mask),
        .brightness_i (brightness),
        .load_i       (load),
        .load_ack_o   (load_ack),
        .frame_tick_o (frame_tick),
        .seg_o        (seg),
        .an_o         (an)
    );

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  bright;
    } tdat_t;

    tdat_t RSTD = '{value: 16'h0,    dp: 4'h0,    blank: 4'hF,    bright: 4'h0};
    tdat_t T2   = '{value: 16'h1234, dp: 4'h0,    blank: 4'h0,    bright: 4'hF};
    tdat_t T3   = '{value: 16'h1234, dp: 4'h0,    blank: 4'h0,    bright: 4'h0};
    tdat_t T4   = '{value: 16'hABCF, dp: 4'b0001, blank: 4'b1000, bright: 4'hF};
    tdat_t D1   = '{value: 16'h1111, dp: 4'h0,    blank: 4'h0,    bright: 4'hF};
    tdat_t D2   = '{value: 16'h2222, dp: 4'h0,    blank: 4'h0,    bright: 4'hF};
    tdat_t D3   = '{value: 16'h3333, dp: 4'h0,    blank: 4'h0,    bright: 4'hF};
    tdat_t D4   = '{value: 16'h4444, dp: 4'h0,    blank: 4'h0,    bright: 4'hF};
    tdat_t NOD  = '0;

    int n_chk = 0;
    int n_bad = 0;

    logic [3:0] obs_an  [FR];
    logic [7:0] obs_seg [FR];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dec7(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    function automatic logic exp_on(input tdat_t d, input int dig, input int k);
        return !d.blank[dig] && (k >= GC) && (k < GC + (int'(d.bright) + 1) * ((DC - GC) / 16));
    endfunction

    function automatic logic [3:0] exp_an(input tdat_t d, input int dig, input int k);
        logic [3:0] one = 4'b0001;
        return exp_on(d, dig, k) ? ~(one << dig) : 4'hF;
    endfunction

    function automatic logic [7:0] exp_seg(input tdat_t d, input int dig, input int k);
        logic [3:0] nib = d.value[dig*4 +: 4];
        logic [7:0] s   = dec7(nib);
        return exp_on(d, dig, k) ? {~d.dp[dig], s[6:0]} : 8'hFF;
    endfunction

    task automatic drive_load(input tdat_t d);
        value      = d.value;
        dp_mask    = d.dp;
        blank_mask = d.blank;
        brightness = d.bright;
        load       = 1'b1;
    endtask

    task automatic check_cycle(input string fn, input tdat_t d, input int r, input logic ack_exp);
        int dig = r / DC;
        int k   = r % DC;
        check_val($sformatf("%s_c%0d_an", fn, r),   32'(an),         32'(exp_an(d, dig, k)));
        check_val($sformatf("%s_c%0d_seg", fn, r),  32'(seg),        32'(exp_seg(d, dig, k)));
        check_val($sformatf("%s_c%0d_tick", fn, r), 32'(frame_tick), 32'(r == 0));
        check_val($sformatf("%s_c%0d_ack", fn, r),  32'(load_ack),   32'((r == 0) && ack_exp));
        obs_an[r]  = an;
        obs_seg[r] = seg;
    endtask

    // One frame sampled on negedges; a load driven after cycle r is sampled on the following posedge.
    task automatic run_frame(input string fn, input tdat_t d, input logic ack_exp,
                             input int la0, input tdat_t l0, input int la1, input tdat_t l1,
                             input int la2, input tdat_t l2);
        for (int r = 0; r < FR; r++) begin
            @(negedge clk);
            check_cycle(fn, d, r, ack_exp);
            load = 1'b0;
            if (r == la0) drive_load(l0);
            if (r == la1) drive_load(l1);
            if (r == la2) drive_load(l2);
        end
    endtask

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        value      = 16'h0;
        dp_mask    = 4'h0;
        blank_mask = 4'h0;
        brightness = 4'h0;
        repeat (3) @(negedge clk);
        check_val("rst_an",   32'(an),         32'hF);
        check_val("rst_seg",  32'(seg),        32'hFF);
        check_val("rst_tick", 32'(frame_tick), 32'h0);
        check_val("rst_ack",  32'(load_ack),   32'h0);
        rst = 1'b0;

        // Blank after reset, ticks every frame, no ack.
        run_frame("f0", RSTD, 1'b0, NL, NOD, NL, NOD, NL, NOD);
        run_frame("f1", RSTD, 1'b0, 20, T2, NL, NOD, NL, NOD);

        // Full brightness 1234.
        run_frame("f2", T2, 1'b1, 30, T3, NL, NOD, NL, NOD);
        check_val("t2_d0_guard_an", 32'(obs_an[7]),    32'hF);
        check_val("t2_d0_on_an",    32'(obs_an[8]),    32'hE);
        check_val("t2_d0_seg",      32'(obs_seg[39]),  32'h99);
        check_val("t2_d1_an",       32'(obs_an[60]),   32'hD);
        check_val("t2_d1_seg",      32'(obs_seg[60]),  32'hB0);
        check_val("t2_d2_an",       32'(obs_an[100]),  32'hB);
        check_val("t2_d2_seg",      32'(obs_seg[100]), 32'hA4);
        check_val("t2_d3_an",       32'(obs_an[159]),  32'h7);
        check_val("t2_d3_seg",      32'(obs_seg[159]), 32'hF9);

        // Minimum brightness: two ON cycles per slot.
        run_frame("f3", T3, 1'b1, 0, T4, NL, NOD, NL, NOD);
        check_val("t3_d0_k7_an",  32'(obs_an[7]),  32'hF);
        check_val("t3_d0_k9_an",  32'(obs_an[9]),  32'hE);
        check_val("t3_d0_k10_an", 32'(obs_an[10]), 32'hF);
        check_val("t3_d1_k9_an",  32'(obs_an[49]), 32'hD);
        check_val("t3_d1_k10_an", 32'(obs_an[50]), 32'hF);

        // Hex letters, decimal point, blanked digit3.
        run_frame("f4", T4, 1'b1, NL, NOD, NL, NOD, NL, NOD);
        check_val("t4_d0_seg", 32'(obs_seg[20]),  32'h0E);
        check_val("t4_d1_seg", 32'(obs_seg[60]),  32'hC6);
        check_val("t4_d2_seg", 32'(obs_seg[100]), 32'h83);
        check_val("t4_d3_an",  32'(obs_an[140]),  32'hF);

        // Last-wins pending, and a load exactly on the boundary edge.
        run_frame("f5", T4, 1'b0, 10, D1, 50, D2, FR - 2, D3);
        run_frame("f6", D2, 1'b1, NL, NOD, NL, NOD, NL, NOD);
        check_val("t5_f6_seg", 32'(obs_seg[20]), 32'hA4);
        run_frame("f7", D3, 1'b1, NL, NOD, NL, NOD, NL, NOD);
        check_val("t5_f7_seg", 32'(obs_seg[20]), 32'hB0);

        // Reset during digit2 ON with a load pending.
        for (int r = 0; r <= 100; r++) begin
            @(negedge clk);
            check_cycle("f8", D3, r, 1'b0);
            load = 1'b0;
            if (r == 5) drive_load(D4);
        end
        check_val("t6_pre_an", 32'(an), 32'hB);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_an",   32'(an),         32'hF);
        check_val("t6_rst_seg",  32'(seg),        32'hFF);
        check_val("t6_rst_tick", 32'(frame_tick), 32'h0);
        check_val("t6_rst_ack",  32'(load_ack),   32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_frame("f9",  RSTD, 1'b0, NL, NOD, NL, NOD, NL, NOD);
        run_frame("f10", RSTD, 1'b0, NL, NOD, NL, NOD, NL, NOD);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
